countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/mw_timer_pkg.sv | 23 ++
 rtl/countdown_timer_bcd_digit_down.sv | 30 +++
 rtl/countdown_timer.sv | 151 +++++++++++++++
 tb/tb_countdown_timer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mw_timer_pkg.sv
// Shared types and limits for the BCD countdown timer.
// Holds the FSM state enum, digit limits and the digit saturation helper.
package mw_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] DIGIT_MAX    = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam int         PRESC_W      = 8;

  function automatic logic [3:0] sat_digit(
    input logic [3:0] d,
    input logic [3:0] max
  );
    return (d > max) ? max : d;
  endfunction

endpackage

// File: rtl/countdown_timer_bcd_digit_down.sv
// One BCD down-counting digit with saturating load and borrow-out.
// Ports: clk, clr (sync zero), load/din, dec, q (digit), borrow.
import mw_timer_pkg::*;

module bcd_digit_down #(
  parameter logic [3:0] MODULUS = DIGIT_MAX
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] din,
  input  logic       dec,
  output logic [3:0] q,
  output logic       borrow
);

  // Borrow to the next digit when decrementing through zero.
  assign borrow = dec && (q == 4'd0);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= 4'd0;
    end else if (load) begin
      q <= sat_digit(din, MODULUS);
    end else if (dec) begin
      q <= (q == 4'd0) ? MODULUS : q - 4'd1;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer with load/start/stop/cancel control.
// Ports: clk, clear, tick, load + ld_* digits, start, stop, cancel; mt/mu/st/su, running, done.
import mw_timer_pkg::*;

module countdown_timer #(
  parameter int TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       tick,
  input  logic       load,
  input  logic [3:0] ld_mt,
  input  logic [3:0] ld_mu,
  input  logic [3:0] ld_st,
  input  logic [3:0] ld_su,
  input  logic       start,
  input  logic       stop,
  input  logic       cancel,
  output logic [3:0] mt,
  output logic [3:0] mu,
  output logic [3:0] st,
  output logic [3:0] su,
  output logic       running,
  output logic       done
);

  localparam logic [PRESC_W-1:0] DIV_LAST =
    PRESC_W'(TICK_DIV - 1);

  state_t state, state_nxt;
  logic [PRESC_W-1:0] presc, presc_nxt;
  logic done_nxt;
  logic dig_clr, dig_load, dig_dec;
  logic clr_all;
  logic is_zero, is_one;
  logic b_su, b_st, b_mu, b_mt;

  assign is_zero = (mt == 4'd0) && (mu == 4'd0)
                && (st == 4'd0) && (su == 4'd0);
  assign is_one  = (mt == 4'd0) && (mu == 4'd0)
                && (st == 4'd0) && (su == 4'd1);

  // A borrow out of the top digit would wrap to 99:59;
  // floor the count at 00:00 instead.
  assign clr_all = clear | dig_clr | b_mt;

  assign running = (state == ST_RUN);

  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    done_nxt  = 1'b0;
    dig_clr   = 1'b0;
    dig_load  = 1'b0;
    dig_dec   = 1'b0;
    if (cancel) begin
      state_nxt = ST_IDLE;
      presc_nxt = '0;
      dig_clr   = 1'b1;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (stop) begin
            state_nxt = ST_PAUSE;
          end else if (tick) begin
            if (presc == DIV_LAST) begin
              presc_nxt = '0;
              dig_dec   = !is_zero;
              if (is_one) begin
                state_nxt = ST_DONE;
                done_nxt  = 1'b1;
              end
            end else begin
              presc_nxt = presc + 1'b1;
            end
          end
        end
        ST_IDLE, ST_PAUSE: begin
          if (start && !is_zero) begin
            state_nxt = ST_RUN;
            // Resume keeps the partial second; fresh start does not.
            if (state == ST_IDLE) presc_nxt = '0;
          end else if (load) begin
            dig_load  = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        ST_DONE: begin
          if (load) begin
            dig_load  = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state <= ST_IDLE;
      presc <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      presc <= presc_nxt;
      done  <= done_nxt;
    end
  end

  bcd_digit_down #(.MODULUS(DIGIT_MAX)) u_su (
    .clk    (clk),
    .clr    (clr_all),
    .load   (dig_load),
    .din    (ld_su),
    .dec    (dig_dec),
    .q      (su),
    .borrow (b_su)
  );

  bcd_digit_down #(.MODULUS(SEC_TENS_MAX)) u_st (
    .clk    (clk),
    .clr    (clr_all),
    .load   (dig_load),
    .din    (ld_st),
    .dec    (b_su),
    .q      (st),
    .borrow (b_st)
  );

  bcd_digit_down #(.MODULUS(DIGIT_MAX)) u_mu (
    .clk    (clk),
    .clr    (clr_all),
    .load   (dig_load),
    .din    (ld_mu),
    .dec    (b_st),
    .q      (mu),
    .borrow (b_mu)
  );

  bcd_digit_down #(.MODULUS(DIGIT_MAX)) u_mt (
    .clk    (clk),
    .clr    (clr_all),
    .load   (dig_load),
    .din    (ld_mt),
    .dec    (b_mu),
    .q      (mt),
    .borrow (b_mt)
  );

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer.
// Two instances share stimulus: TICK_DIV=1 and TICK_DIV=4.
import mw_timer_pkg::*;

module tb_countdown_timer;

  logic clk = 1'b0;
  logic clear, tick, load, start, stop, cancel;
  logic [3:0] ld_mt, ld_mu, ld_st, ld_su;
  logic [3:0] mt1, mu1, st1, su1;
  logic [3:0] mt4, mu4, st4, su4;
  logic run1, done1, run4, done4;
  logic [15:0] cnt1, cnt4;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  assign cnt1 = {mt1, mu1, st1, su1};
  assign cnt4 = {mt4, mu4, st4, su4};

  countdown_timer #(.TICK_DIV(1)) dut1 (
    .clk(clk), .clear(clear), .tick(tick), .load(load),
    .ld_mt(ld_mt), .ld_mu(ld_mu), .ld_st(ld_st), .ld_su(ld_su),
    .start(start), .stop(stop), .cancel(cancel),
    .mt(mt1), .mu(mu1), .st(st1), .su(su1),
    .running(run1), .done(done1)
  );

  countdown_timer #(.TICK_DIV(4)) dut4 (
    .clk(clk), .clear(clear), .tick(tick), .load(load),
    .ld_mt(ld_mt), .ld_mu(ld_mu), .ld_st(ld_st), .ld_su(ld_su),
    .start(start), .stop(stop), .cancel(cancel),
    .mt(mt4), .mu(mu4), .st(st4), .su(su4),
    .running(run4), .done(done4)
  );

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    clear = 0; tick = 0; load = 0;
    start = 0; stop = 0; cancel = 0;
  endtask

  task automatic do_clear();
    clear = 1; step(); clear = 0;
  endtask

  task automatic do_load(input logic [3:0] a, b, c, d);
    ld_mt = a; ld_mu = b; ld_st = c; ld_su = d;
    load = 1; step(); load = 0;
  endtask

  task automatic do_start();
    start = 1; step(); start = 0;
  endtask

  task automatic do_stop();
    stop = 1; step(); stop = 0;
  endtask

  task automatic do_tick(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1; step(); tick = 0;
    end
  endtask

  initial begin
    quiet();
    ld_mt = 0; ld_mu = 0; ld_st = 0; ld_su = 0;

    // reset state
    do_clear();
    chk("rst_cnt", cnt1, 16'h0000);
    chk("rst_run", 16'(run1), 16'd0);
    chk("rst_done", 16'(done1), 16'd0);
    chk("rst_state", 16'(dut1.state), 16'(ST_IDLE));

    // 00:03 countdown to done
    do_load(0, 0, 0, 3);
    chk("t1_load", cnt1, 16'h0003);
    do_start();
    chk("t1_run", 16'(run1), 16'd1);
    do_tick(1);
    chk("t1_c2", cnt1, 16'h0002);
    do_tick(1);
    chk("t1_c1", cnt1, 16'h0001);
    chk("t1_nodone", 16'(done1), 16'd0);
    do_tick(1);
    chk("t1_c0", cnt1, 16'h0000);
    chk("t1_done", 16'(done1), 16'd1);
    chk("t1_state", 16'(dut1.state), 16'(ST_DONE));
    step();
    chk("t1_done_pulse", 16'(done1), 16'd0);
    do_start();
    chk("t1_start_done", 16'(dut1.state), 16'(ST_DONE));

    // borrow across minutes
    do_clear();
    do_load(1, 0, 0, 0);
    do_tick(1);
    chk("t2_idle_tick", cnt1, 16'h1000);
    do_start();
    do_tick(1);
    chk("t2_0959", cnt1, 16'h0959);
    do_tick(1);
    chk("t2_0958", cnt1, 16'h0958);

    // pause and resume
    do_clear();
    do_load(0, 0, 0, 5);
    do_start();
    do_tick(2);
    chk("t3_0003", cnt1, 16'h0003);
    do_stop();
    chk("t3_paused", 16'(run1), 16'd0);
    do_tick(3);
    chk("t3_frozen", cnt1, 16'h0003);
    chk("t3_run_lo", 16'(run1), 16'd0);
    do_start();
    chk("t3_resume", 16'(run1), 16'd1);
    do_tick(1);
    chk("t3_0002", cnt1, 16'h0002);

    // saturation and start at zero
    do_clear();
    do_load(0, 0, 7, 12);
    chk("t4_sat59", cnt1, 16'h0059);
    do_load(15, 10, 9, 9);
    chk("t4_sat9959", cnt1, 16'h9959);
    do_tick(1);
    do_start();
    do_tick(1);
    chk("t4_max_dec", cnt1, 16'h9958);
    do_clear();
    do_start();
    chk("t4_zero_start", 16'(dut1.state), 16'(ST_IDLE));
    chk("t4_zero_run", 16'(run1), 16'd0);

    // TICK_DIV=4 prescaler and stop+tick
    do_clear();
    do_load(0, 0, 0, 2);
    do_start();
    do_tick(3);
    chk("t5_3ticks", cnt4, 16'h0002);
    do_tick(1);
    chk("t5_4ticks", cnt4, 16'h0001);
    do_tick(3);
    chk("t5_pre3", cnt4, 16'h0001);
    stop = 1; tick = 1; step(); stop = 0; tick = 0;
    chk("t5_stop_tick", cnt4, 16'h0001);
    chk("t5_paused", 16'(run4), 16'd0);
    do_start();
    do_tick(1);
    chk("t5_resume", cnt4, 16'h0000);
    chk("t5_done", 16'(done4), 16'd1);

    // cancel during RUN, load ignored in RUN
    do_clear();
    do_load(0, 5, 3, 0);
    do_start();
    do_load(0, 1, 0, 0);
    chk("t6_ld_ign", cnt1, 16'h0530);
    cancel = 1; step(); cancel = 0;
    chk("t6_cnt", cnt1, 16'h0000);
    chk("t6_state", 16'(dut1.state), 16'(ST_IDLE));
    chk("t6_done", 16'(done1), 16'd0);

    // clear during RUN
    do_load(0, 5, 3, 0);
    do_start();
    chk("t7_run", 16'(run1), 16'd1);
    do_clear();
    chk("t7_cnt", cnt1, 16'h0000);
    chk("t7_state", 16'(dut1.state), 16'(ST_IDLE));
    chk("t7_done", 16'(done1), 16'd0);
    step();
    chk("t7_done2", 16'(done1), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
